arb_req_client: RTL

//  Requester-side agent for the 3-way fixed-priority request/grant arbiter (r[i] -> g[i]).

---
 rtl/arb_pkg.sv | 17 +
 rtl/arb_req_timer.sv | 33 +++
 rtl/arb_req_client.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the request/grant arbiter and its requester agents.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2,
        REL  = 2'd3
    } arb_state_e;

    localparam int ARB_PORTS = 3;

    function automatic logic req_active(input arb_state_e st);
        return (st == REQ) || (st == BUSY);
    endfunction

endpackage

// File: rtl/arb_req_timer.sv
// Counts ungranted request cycles; expired flags the last cycle a request may wait.
module arb_req_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int              TO_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic            HAS_TO = (TIMEOUT > 0);
    localparam logic [TO_W-1:0] LAST   = TO_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [TO_W-1:0] count_r;

    // wait-cycle counter, restarted whenever a new job is accepted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_r <= {TO_W{1'b0}};
        end else if (clear) begin
            count_r <= {TO_W{1'b0}};
        end else if (enable) begin
            count_r <= count_r + TO_W'(1'b1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = HAS_TO && (count_r == LAST);

endmodule

// File: rtl/arb_req_client.sv
// Requester-side agent for the fixed-priority arbiter: takes a burst job, requests,
// emits one beat per granted cycle, then releases and waits for the grant to fall.
module arb_req_client
    import arb_pkg::*;
#(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    output logic             r,
    input  logic             g,
    output logic             beat_en,
    output logic             done,
    output logic             timeout,
    output logic             busy,
    output logic             spurious_g
);

    arb_state_e       state_r;
    arb_state_e       state_nxt_s;
    logic [LEN_W-1:0] rem_r;
    logic [LEN_W-1:0] rem_nxt_s;
    logic             last_beat_s;
    logic             tmr_clear_s;
    logic             tmr_en_s;
    logic             tmr_expired_s;
    logic             done_nxt_s;
    logic             timeout_nxt_s;
    logic             r_r;
    logic             job_ready_r;
    logic             busy_r;
    logic             done_r;
    logic             timeout_r;
    logic             spurious_r;

    assign last_beat_s = (rem_r == {LEN_W{1'b0}});

    arb_req_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (tmr_clear_s),
        .enable  (tmr_en_s),
        .expired (tmr_expired_s)
    );

    // next-state, remaining-beat and pulse decode
    always_comb begin
        state_nxt_s   = state_r;
        rem_nxt_s     = rem_r;
        tmr_clear_s   = 1'b0;
        tmr_en_s      = 1'b0;
        done_nxt_s    = 1'b0;
        timeout_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (job_valid) begin
                    state_nxt_s = REQ;
                    rem_nxt_s   = job_len;
                    tmr_clear_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (g) begin
                    if (last_beat_s) begin
                        state_nxt_s = REL;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = BUSY;
                        rem_nxt_s   = rem_r - LEN_W'(1'b1);
                    end
                end else if (tmr_expired_s) begin
                    state_nxt_s   = REL;
                    timeout_nxt_s = 1'b1;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            BUSY: begin
                // a dropped grant while holding r is a stall, never an abort
                if (g) begin
                    if (last_beat_s) begin
                        state_nxt_s = REL;
                        done_nxt_s  = 1'b1;
                    end else begin
                        rem_nxt_s = rem_r - LEN_W'(1'b1);
                    end
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            REL: begin
                if (!g) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = REL;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // state and remaining-beat registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
            rem_r   <= {LEN_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            rem_r   <= rem_nxt_s;
        end
    end

    // output flops track the state being entered so they always match state_r
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_r         <= 1'b0;
            job_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            spurious_r  <= 1'b0;
        end else begin
            r_r         <= req_active(state_nxt_s);
            job_ready_r <= (state_nxt_s == IDLE);
            busy_r      <= (state_nxt_s != IDLE);
            done_r      <= done_nxt_s;
            timeout_r   <= timeout_nxt_s;
            spurious_r  <= spurious_r | ((state_r == IDLE) & g);
        end
    end

    assign beat_en    = req_active(state_r) && g;
    assign r          = r_r;
    assign job_ready  = job_ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign timeout    = timeout_r;
    assign spurious_g = spurious_r;

endmodule
